// File: rtl/vga_grid_scanner.sv
// vga_grid_scanner: VGA raster timing with play-field cell mapping; VGA_SYNC_DELAY_EN delays hsync/vsync/blank_n by one tick
module vga_grid_scanner #(
    parameter int H_ACTIVE   = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter int CELL_PX    = 10,
    parameter int GAME_CELLS = 48,
    parameter int GAME_X0    = 80,
    parameter int GAME_Y0    = 0
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_en,
    output logic       o_hsync,
    output logic       o_vsync,
    output logic       o_blank_n,
    output logic       o_game_valid,
    output logic [5:0] o_game_x,
    output logic [5:0] o_game_y,
    output logic [3:0] o_grid_x,
    output logic [3:0] o_grid_y,
    output logic       o_line_start,
    output logic       o_frame_start
);
    localparam logic [9:0] H_LAST    = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0] V_LAST    = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam int         GAME_PX   = GAME_CELLS * CELL_PX;
    localparam logic [3:0] CELL_LAST = 4'(CELL_PX - 1);

    // wrap-around subtraction makes one compare cover both ends of the range
    function automatic logic in_rng(input logic [9:0] x, input int lo, input int len);
        return (x - 10'(lo)) < 10'(len);
    endfunction

    logic [9:0] h_cnt, v_cnt, h_nxt, v_nxt;
    logic [5:0] game_x, game_y, game_x_nxt, game_y_nxt;
    logic [3:0] grid_x, grid_y, grid_x_nxt, grid_y_nxt;
    logic       started, h_wrap, hx_in, vy_in, hs_c, vs_c, bl_c;

    // next raster position and cell counters; a counter steps only when both current and next position are in the field
    always_comb begin
        h_wrap     = h_cnt == H_LAST;
        h_nxt      = h_wrap ? '0 : h_cnt + 10'd1;
        v_nxt      = h_wrap ? (v_cnt == V_LAST ? '0 : v_cnt + 10'd1) : v_cnt;
        hx_in      = in_rng(h_cnt, GAME_X0, GAME_PX) && in_rng(h_nxt, GAME_X0, GAME_PX);
        vy_in      = in_rng(v_cnt, GAME_Y0, GAME_PX) && in_rng(v_nxt, GAME_Y0, GAME_PX);
        grid_x_nxt = (!hx_in || grid_x == CELL_LAST) ? '0 : grid_x + 4'd1;
        game_x_nxt = !hx_in ? '0 : game_x + 6'(grid_x == CELL_LAST);
        grid_y_nxt = (!vy_in || grid_y == CELL_LAST) ? '0 : grid_y + 4'd1;
        game_y_nxt = !vy_in ? '0 : game_y + 6'(grid_y == CELL_LAST);
        hs_c       = !in_rng(h_cnt, H_ACTIVE + H_FP, H_SYNC);
        vs_c       = !in_rng(v_cnt, V_ACTIVE + V_FP, V_SYNC);
        bl_c       = h_cnt < 10'(H_ACTIVE) && v_cnt < 10'(V_ACTIVE);
    end

    // raster and cell state; vertical cell counters step on the line wrap only
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            h_cnt   <= '0;
            v_cnt   <= '0;
            game_x  <= '0;
            grid_x  <= '0;
            game_y  <= '0;
            grid_y  <= '0;
            started <= 1'b0;
        end else if (i_en) begin
            h_cnt  <= h_nxt;
            v_cnt  <= v_nxt;
            game_x <= game_x_nxt;
            grid_x <= grid_x_nxt;
            if (h_wrap) begin
                game_y  <= game_y_nxt;
                grid_y  <= grid_y_nxt;
                started <= 1'b1;
            end
        end
    end

    assign o_game_valid  = in_rng(h_cnt, GAME_X0, GAME_PX) && in_rng(v_cnt, GAME_Y0, GAME_PX);
    assign o_game_x      = o_game_valid ? game_x : '0;
    assign o_game_y      = o_game_valid ? game_y : '0;
    assign o_grid_x      = grid_x;
    assign o_grid_y      = grid_y;
    assign o_line_start  = started && h_cnt == '0;
    assign o_frame_start = o_line_start && v_cnt == '0;

`ifdef VGA_SYNC_DELAY_EN
    logic hs_d, vs_d, bl_d;

    // one-tick delay on syncs and blanking to line up with a registered colour stage
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            hs_d <= 1'b1;
            vs_d <= 1'b1;
            bl_d <= 1'b1;
        end else if (i_en) begin
            hs_d <= hs_c;
            vs_d <= vs_c;
            bl_d <= bl_c;
        end
    end

    assign o_hsync   = hs_d;
    assign o_vsync   = vs_d;
    assign o_blank_n = bl_d;
`else
    assign o_hsync   = hs_c;
    assign o_vsync   = vs_c;
    assign o_blank_n = bl_c;
`endif
endmodule

// File: tb/tb_vga_grid_scanner.sv
// tb_vga_grid_scanner: scoreboard bench for vga_grid_scanner (default and a scaled-down timing instance)
module tb_vga_grid_scanner;
    typedef struct {
        int ha, hfp, hs, hb, va, vfp, vs, vb, cpx, cells, x0, y0;
    } cfg_t;
    typedef struct {
        int hs, vs, bl, val, ls, fs, gx, gy, rx, ry;
    } exp_t;

    localparam int S_HA = 64, S_HFP = 4, S_HS = 8, S_HB = 4;
    localparam int S_VA = 48, S_VFP = 3, S_VS = 2, S_VB = 5;
    localparam int S_CPX = 4, S_CELLS = 8, S_X0 = 16, S_Y0 = 8;

    logic       clk = 1'b0;
    logic       rst_n, en;
    logic       hs_o [2], vs_o [2], bl_o [2], val_o [2], ls_o [2], fs_o [2];
    logic [5:0] gx_o [2], gy_o [2];
    logic [3:0] rx_o [2], ry_o [2];

    cfg_t cfg [2];
    exp_t q0 [$], q1 [$];
    int   t = 0, n_chk = 0, n_fail = 0;

    always #5 clk = ~clk;

    vga_grid_scanner dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_en(en),
        .o_hsync(hs_o[0]), .o_vsync(vs_o[0]), .o_blank_n(bl_o[0]), .o_game_valid(val_o[0]),
        .o_game_x(gx_o[0]), .o_game_y(gy_o[0]), .o_grid_x(rx_o[0]), .o_grid_y(ry_o[0]),
        .o_line_start(ls_o[0]), .o_frame_start(fs_o[0])
    );

    vga_grid_scanner #(
        .H_ACTIVE(S_HA), .H_FP(S_HFP), .H_SYNC(S_HS), .H_BP(S_HB),
        .V_ACTIVE(S_VA), .V_FP(S_VFP), .V_SYNC(S_VS), .V_BP(S_VB),
        .CELL_PX(S_CPX), .GAME_CELLS(S_CELLS), .GAME_X0(S_X0), .GAME_Y0(S_Y0)
    ) dut_s (
        .i_clk(clk), .i_rst_n(rst_n), .i_en(en),
        .o_hsync(hs_o[1]), .o_vsync(vs_o[1]), .o_blank_n(bl_o[1]), .o_game_valid(val_o[1]),
        .o_game_x(gx_o[1]), .o_game_y(gy_o[1]), .o_grid_x(rx_o[1]), .o_grid_y(ry_o[1]),
        .o_line_start(ls_o[1]), .o_frame_start(fs_o[1])
    );

    // outputs after t enabled ticks since reset, from raster arithmetic
    function automatic exp_t model(int tk, cfg_t c);
        exp_t e;
        int htot = c.ha + c.hfp + c.hs + c.hb;
        int vtot = c.va + c.vfp + c.vs + c.vb;
        int h = tk % htot;
        int v = (tk / htot) % vtot;
        int dx = h - c.x0;
        int dy = v - c.y0;
        int span = c.cells * c.cpx;
        e.val = int'(dx >= 0 && dx < span && dy >= 0 && dy < span);
        e.bl  = int'(h < c.ha && v < c.va);
        e.hs  = int'(!(h >= c.ha + c.hfp && h < c.ha + c.hfp + c.hs));
        e.vs  = int'(!(v >= c.va + c.vfp && v < c.va + c.vfp + c.vs));
        e.gx  = e.val != 0 ? dx / c.cpx : 0;
        e.gy  = e.val != 0 ? dy / c.cpx : 0;
        e.rx  = e.val != 0 ? dx % c.cpx : 0;
        e.ry  = e.val != 0 ? dy % c.cpx : 0;
        e.ls  = int'(tk >= htot && h == 0);
        e.fs  = int'(e.ls != 0 && v == 0);
        return e;
    endfunction

    function automatic exp_t expect_at(int tk, cfg_t c);
        exp_t e = model(tk, c);
`ifdef VGA_SYNC_DELAY_EN
        exp_t p = model(tk > 0 ? tk - 1 : 0, c);
        e.hs = p.hs;
        e.vs = p.vs;
        e.bl = p.bl;
`endif
        return e;
    endfunction

    task automatic check(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at t=%0d: got %0d, expected %0d", nm, t, act, exp);
        end
    endtask

    task automatic cmp(input int k, input exp_t e);
        string p = k == 0 ? "dut" : "dut_s";
        check({p, ".hsync"}, int'(hs_o[k]), e.hs);
        check({p, ".vsync"}, int'(vs_o[k]), e.vs);
        check({p, ".blank_n"}, int'(bl_o[k]), e.bl);
        check({p, ".game_valid"}, int'(val_o[k]), e.val);
        check({p, ".game_x"}, int'(gx_o[k]), e.gx);
        check({p, ".game_y"}, int'(gy_o[k]), e.gy);
        check({p, ".line_start"}, int'(ls_o[k]), e.ls);
        check({p, ".frame_start"}, int'(fs_o[k]), e.fs);
        if (e.val != 0) begin
            check({p, ".grid_x"}, int'(rx_o[k]), e.rx);
            check({p, ".grid_y"}, int'(ry_o[k]), e.ry);
        end
    endtask

    // monitor: outputs are presented every cycle, compare against the oldest expectation
    always @(negedge clk) begin
        if (q0.size() > 0) cmp(0, q0.pop_front());
        if (q1.size() > 0) cmp(1, q1.pop_front());
    end

    task automatic tick(input bit e);
        en = e;
        @(posedge clk);
        if (rst_n && e) t++;
        q0.push_back(expect_at(t, cfg[0]));
        q1.push_back(expect_at(t, cfg[1]));
        #1;
    endtask

    initial begin
        cfg[0] = '{640, 16, 96, 48, 480, 10, 2, 33, 10, 48, 80, 0};
        cfg[1] = '{S_HA, S_HFP, S_HS, S_HB, S_VA, S_VFP, S_VS, S_VB, S_CPX, S_CELLS, S_X0, S_Y0};
        rst_n = 1'b0;
        en = 1'b0;
        repeat (3) tick(1'b1);
        rst_n = 1'b1;
        repeat (9605) tick(1'b1);
        repeat (16000) tick($urandom_range(0, 3) == 0);
        repeat (3000) tick(1'b1);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        t = 0;
        repeat (2) tick(1'b1);
        rst_n = 1'b1;
        repeat (5000) tick(1'b1);
        @(negedge clk);
        #1;
        check("queue_drained", q0.size() + q1.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
